// File: rtl/pow_pipe.sv
// pow_pipe: fixed-latency pipelined integer power unit, m_tdata = s_tdata ** s_tpow
// modulo 2^DATA_W.
//
// The unit has MAX_POW lock-step stages. Stage 0 loads the base operand. Each later
// stage multiplies the accumulator by the base once, while its remaining count is
// non-zero. An exponent above MAX_POW is clamped to MAX_POW, and the beat leaves
// with m_terr set. Every stage advances together when the output slot is empty or
// is being consumed. Bubbles are not collapsed.
//
// Ports
//   clk, aresetn                 clock and async active-low reset
//   s_tvalid/s_tready            input handshake (s_tready = advance enable)
//   s_tdata, s_tpow, s_tid       base, exponent and stream id of the input beat
//   m_tvalid/m_tready            output handshake
//   m_tdata, m_tid, m_terr       result, pass-through id, exponent-out-of-range flag
module pow_pipe #(
    parameter int DATA_W  = 32,
    parameter int ID_W    = 1,
    parameter int MAX_POW = 5,
    localparam int POW_W  = $clog2(MAX_POW + 1)
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [POW_W-1:0]  s_tpow,
    input  logic [ID_W-1:0]   s_tid,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [ID_W-1:0]   m_tid,
    output logic              m_terr
);

    localparam logic [POW_W-1:0] POW_MAX = POW_W'(MAX_POW);

    logic [MAX_POW-1:0] vld_q, vld_d;
    logic [MAX_POW-1:0] err_q, err_d;
    logic [DATA_W-1:0]  acc_q  [MAX_POW];
    logic [DATA_W-1:0]  acc_d  [MAX_POW];
    logic [DATA_W-1:0]  base_q [MAX_POW];
    logic [DATA_W-1:0]  base_d [MAX_POW];
    logic [POW_W-1:0]   rem_q  [MAX_POW];
    logic [POW_W-1:0]   rem_d  [MAX_POW];
    logic [ID_W-1:0]    id_q   [MAX_POW];
    logic [ID_W-1:0]    id_d   [MAX_POW];

    logic              en;
    logic              pow_over;
    logic [POW_W-1:0]  pow_eff;

    assign m_tvalid = vld_q[MAX_POW-1];
    assign m_tdata  = acc_q[MAX_POW-1];
    assign m_tid    = id_q[MAX_POW-1];
    assign m_terr   = err_q[MAX_POW-1];

    // An empty output slot still enables the pipeline, so bubbles drain freely.
    assign en       = ~vld_q[MAX_POW-1] | m_tready;
    assign s_tready = en;

    assign pow_over = (s_tpow > POW_MAX);
    assign pow_eff  = pow_over ? POW_MAX : s_tpow;

    always_comb begin
        vld_d  = vld_q;
        err_d  = err_q;
        acc_d  = acc_q;
        base_d = base_q;
        rem_d  = rem_q;
        id_d   = id_q;
        if (en) begin
            // Stage 0 already holds x^1, so one fewer multiply is pending.
            vld_d[0]  = s_tvalid;
            err_d[0]  = pow_over;
            acc_d[0]  = (s_tpow == '0) ? DATA_W'(1) : s_tdata;
            base_d[0] = s_tdata;
            rem_d[0]  = (pow_eff == '0) ? '0 : pow_eff - POW_W'(1);
            id_d[0]   = s_tid;
            for (int k = 1; k < MAX_POW; k++) begin
                vld_d[k]  = vld_q[k-1];
                err_d[k]  = err_q[k-1];
                base_d[k] = base_q[k-1];
                id_d[k]   = id_q[k-1];
                if (rem_q[k-1] != '0) begin
                    acc_d[k] = acc_q[k-1] * base_q[k-1];
                    rem_d[k] = rem_q[k-1] - POW_W'(1);
                end else begin
                    acc_d[k] = acc_q[k-1];
                    rem_d[k] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            vld_q <= '0;
            err_q <= '0;
            for (int k = 0; k < MAX_POW; k++) begin
                acc_q[k]  <= '0;
                base_q[k] <= '0;
                rem_q[k]  <= '0;
                id_q[k]   <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            err_q  <= err_d;
            acc_q  <= acc_d;
            base_q <= base_d;
            rem_q  <= rem_d;
            id_q   <= id_d;
        end
    end

endmodule

// File: tb/tb_pow_pipe.sv
// tb_pow_pipe: directed and randomized checks of pow_pipe (DATA_W=32, ID_W=1, MAX_POW=5).
module tb_pow_pipe;

    localparam int DW = 32;
    localparam int IW = 1;
    localparam int MP = 5;
    localparam int PW = 3;

    logic          clk;
    logic          aresetn;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] s_tdata;
    logic [PW-1:0] s_tpow;
    logic [IW-1:0] s_tid;
    logic          m_tvalid;
    logic          m_tready;
    logic [DW-1:0] m_tdata;
    logic [IW-1:0] m_tid;
    logic          m_terr;

    pow_pipe #(.DATA_W(DW), .ID_W(IW), .MAX_POW(MP)) dut (
        .clk      (clk),
        .aresetn  (aresetn),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tpow   (s_tpow),
        .s_tid    (s_tid),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tid    (m_tid),
        .m_terr   (m_terr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [IW-1:0] id;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   hs_cyc_q[$];
    int   n_chk = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   hs_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pw(input logic [DW-1:0] x, input int e);
        logic [DW-1:0] r;
        int n;
        r = 1;
        n = (e > MP) ? MP : e;
        for (int i = 0; i < n; i++) r = r * x;
        return r;
    endfunction

    // Output monitor: the handshake is sampled mid-cycle, when inputs are stable.
    always @(negedge clk) begin
        exp_t e;
        if (aresetn && m_tvalid && m_tready) begin
            hs_cnt++;
            hs_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("m_tdata", 64'(m_tdata), 64'(e.d));
                chk("m_tid", 64'(m_tid), 64'(e.id));
                chk("m_terr", 64'(m_terr), 64'(e.err));
            end
        end
    end

    // Presents one beat and holds it until accepted; returns at posedge+1 after the accept edge.
    task automatic send(input logic [DW-1:0] x, input logic [PW-1:0] e, input logic [IW-1:0] id,
                        input logic [DW-1:0] ed, input logic er);
        bit done;
        done = 0;
        s_tvalid = 1'b1;
        s_tdata  = x;
        s_tpow   = e;
        s_tid    = id;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (s_tready) begin
                exp_q.push_back('{ed, id, er});
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tdata  = $urandom;
        s_tpow   = PW'($urandom_range(0, 7));
        s_tid    = IW'($urandom % 2);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_left", 64'(exp_q.size()), 64'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    bit rnd_on;
    int n0;
    int lat;
    logic [DW-1:0] snap;

    initial begin
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tpow   = '0;
        s_tid    = '0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_m_tdata", 64'(m_tdata), 64'(0));
        chk("rst_m_tid", 64'(m_tid), 64'(0));
        chk("rst_m_terr", 64'(m_terr), 64'(0));
        chk("rst_s_tready", 64'(s_tready), 64'(1));

        // First beat goes in on the first edge after release; then measure latency.
        aresetn = 1'b1;
        send(32'd3, 3'd5, 1'b0, 32'd243, 1'b0);
        idle();
        lat = 0;
        for (int n = 1; n <= 12 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            if (m_tvalid) lat = n + 1;
        end
        chk("latency", 64'(lat), 64'(5));
        send(32'd7, 3'd0, 1'b1, 32'd1, 1'b0);
        send(32'd9, 3'd1, 1'b0, 32'd9, 1'b0);
        send(32'd2, 3'd7, 1'b1, 32'd32, 1'b1);
        send(32'h10000, 3'd2, 1'b0, 32'd0, 1'b0);
        send(32'd5, 3'd6, 1'b1, 32'd3125, 1'b1);
        idle();
        drain();

        // Back-to-back squares at full rate.
        hs_cyc_q.delete();
        for (int k = 1; k <= 10; k++) send(DW'(k), 3'd2, IW'(k % 2), DW'(k * k), 1'b0);
        idle();
        drain();
        chk("burst_count", 64'(hs_cyc_q.size()), 64'(10));
        if (hs_cyc_q.size() == 10) chk("burst_span", 64'(hs_cyc_q[9] - hs_cyc_q[0]), 64'(9));

        // Same burst with a 3-cycle downstream stall in the middle.
        hs_cyc_q.delete();
        fork
            begin
                for (int k = 1; k <= 10; k++) send(DW'(k), 3'd2, IW'(k % 2), DW'(k * k), 1'b0);
                idle();
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                m_tready = 1'b0;
                snap = m_tdata;
                chk("stall_valid", 64'(m_tvalid), 64'(1));
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_s_tready", 64'(s_tready), 64'(0));
                    chk("stall_hold", 64'(m_tdata), 64'(snap));
                end
                @(posedge clk);
                #1;
                m_tready = 1'b1;
            end
        join
        drain();
        chk("stall_count", 64'(hs_cyc_q.size()), 64'(10));

        // Random valid/ready traffic against the reference power function.
        rnd_on = 1;
        fork
            begin
                for (int b = 0; b < 1000; b++) begin
                    logic [DW-1:0] x;
                    int e;
                    logic [IW-1:0] id;
                    while ($urandom % 2 == 0) begin
                        idle();
                        @(posedge clk);
                        #1;
                    end
                    x  = $urandom;
                    e  = $urandom_range(0, 7);
                    id = IW'($urandom % 2);
                    send(x, PW'(e), id, pw(x, e), (e > MP));
                end
                idle();
                rnd_on = 0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    m_tready = ($urandom % 2 == 1);
                end
            end
        join
        m_tready = 1'b1;
        drain();

        // Reset with three beats in flight, the oldest parked at the output.
        m_tready = 1'b0;
        send(32'd11, 3'd2, 1'b1, 32'd121, 1'b0);
        send(32'd12, 3'd2, 1'b0, 32'd144, 1'b0);
        send(32'd13, 3'd2, 1'b1, 32'd169, 1'b0);
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_valid", 64'(m_tvalid), 64'(1));
        aresetn = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(m_tvalid), 64'(0));
        chk("mid_rst_data", 64'(m_tdata), 64'(0));
        chk("mid_rst_ready", 64'(s_tready), 64'(1));
        exp_q.delete();
        m_tready = 1'b1;
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        n0 = hs_cnt;
        send(32'd4, 3'd3, 1'b1, 32'd64, 1'b0);
        idle();
        drain();
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_outputs", 64'(hs_cnt - n0), 64'(1));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/pow_pipe.md
POW_PIPE -- requirements
Module: pow_pipe

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width in bits.
REQ-002 Parameter: ID_W, 1, stream ID width in bits.
REQ-003 Parameter: MAX_POW, 5, largest supported exponent; legal range >= 2.
REQ-004 Derived constant: POW_W = $clog2(MAX_POW+1), exponent field width.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 aresetn  input  1  reset, asynchronous, active-low.
REQ-007 s_tvalid  input  1  input beat valid.
REQ-008 s_tready  output  1  block accepts input beat.
REQ-009 s_tdata  input  DATA_W  base operand x.
REQ-010 s_tpow  input  POW_W  per-beat exponent e.
REQ-011 s_tid  input  ID_W  stream ID, passed through unchanged.
REQ-012 m_tvalid  output  1  result beat valid.
REQ-013 m_tready  input  1  downstream accepts result.
REQ-014 m_tdata  output  DATA_W  result x^e.
REQ-015 m_tid  output  ID_W  ID of the beat that produced the result.
REQ-016 m_terr  output  1  the beat's exponent was out of range (> MAX_POW).

Function
REQ-017 Pipeline: exactly MAX_POW register stages; each stage holds valid, accumulator, base, remaining-count, id and err.
REQ-018 Stage 0 on accept: accumulator = 1 if e==0, else x; remaining = max(e_eff-1, 0); base = x; err = (e > MAX_POW).
REQ-019 e_eff = min(e, MAX_POW); an out-of-range exponent computes x^MAX_POW and flags m_terr=1.
REQ-020 Stages 1..MAX_POW-1: if remaining > 0, accumulator <= accumulator*base and remaining decrements; otherwise the stage passes the accumulator unchanged.
REQ-021 Arithmetic is modulo 2^DATA_W: keep the low DATA_W bits of each product; overflow is not flagged.
REQ-022 Global advance enable: en = ~m_tvalid | m_tready; when en=1 all stages shift by one; when en=0 every stage holds.
REQ-023 s_tready = en, combinational; a beat is accepted when s_tvalid & s_tready.
REQ-024 When en=1 and s_tvalid=0, a bubble (valid=0) enters stage 0.
REQ-025 Latency is exactly MAX_POW cycles from acceptance to m_tvalid, plus one cycle for each stalled cycle.
REQ-026 Throughput is one beat per cycle while m_tready=1.
REQ-027 m_tvalid, m_tdata, m_tid and m_terr are driven directly from the last stage.
REQ-028 While m_tvalid=1 and m_tready=0, the outputs stay stable until the handshake completes.
REQ-029 Beats leave in acceptance order; no beat is lost, duplicated or reordered under any stall pattern.
REQ-030 Bubbles are not collapsed: an invalid last stage still sets en=1, so bubbles drain freely.
REQ-031 Accept and emit in the same cycle (m_tvalid & m_tready & s_tvalid) is legal and sustains full rate.
REQ-032 The result is independent of the s_tdata, s_tpow and s_tid values seen while s_tready=0.

Reset
REQ-033 While aresetn=0, all stage valid bits clear; m_tvalid=0, m_tdata=0, m_tid=0, m_terr=0.
REQ-034 Reset asserted mid-operation discards all in-flight beats; no stale result appears after release.
REQ-035 s_tready=1 during and immediately after reset.
REQ-036 The first beat after reset release is accepted on the first rising edge with aresetn=1.

Verification (defaults: DATA_W=32, MAX_POW=5)
REQ-037 x=3, e=5, m_tready=1: m_tdata=243, m_terr=0, exactly 5 cycles after accept; x=7, e=0: m_tdata=1; x=9, e=1: m_tdata=9.
REQ-038 x=2, e=7: m_tdata=32, m_terr=1; x=0x10000, e=2: m_tdata=0 (wrap), m_terr=0.
REQ-039 Back-to-back stream x=1..10, e=2, ids alternating 0/1, m_tready=1: outputs 1,4,...,100 on consecutive cycles with matching ids.
REQ-040 Same stream with m_tready held low 3 cycles mid-burst: s_tready=0 and m_tdata stable during the hold; full sequence intact afterwards.
REQ-041 Random s_tvalid/m_tready (50%), 1000 beats, random x and e in 0..7: scoreboard matches (x^min(e,5)) mod 2^32, err flag and id, in order.
REQ-042 aresetn pulsed low with 3 beats in flight: m_tvalid=0 immediately; no result for those beats after release; next beat x=4, e=3 yields 64.
